// File: rtl/spi_slave_if.sv
// SPI slave front end for the single-port RAM: deserialises 10-bit command/data
// words from MOSI and serialises the 8-bit read data back onto MISO.
module spi_slave_if #(
  parameter int RX_W = 10,
  parameter int TX_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            SS_n,
  input  logic            MOSI,
  output logic            MISO,
  output logic [RX_W-1:0] rx_data,
  output logic            rx_valid,
  input  logic [TX_W-1:0] tx_data,
  input  logic            tx_valid
);

  localparam int CW = $clog2(RX_W + 1);
  localparam int TW = $clog2(TX_W + 1);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   bit_cnt;
  logic [RX_W-2:0] shift;
  logic            rd_addr_received;
  logic [TX_W-1:0] cap;
  logic            captured;
  logic [TW-1:0]   tx_cnt;
  logic            shifting, word_last, word_done;

  assign shifting  = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
  assign word_last = (bit_cnt == CW'(RX_W - 1));
  assign word_done = (bit_cnt == CW'(RX_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // SS_n high wins over every other transition
  always_comb begin
    state_nxt = state;
    if (SS_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = CHK_CMD;
        CHK_CMD: state_nxt = !MOSI ? WRITE : (rd_addr_received ? READ_DATA : READ_ADD);
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data          <= '0;
      rx_valid         <= 1'b0;
      MISO             <= 1'b0;
      bit_cnt          <= '0;
      shift            <= '0;
      rd_addr_received <= 1'b0;
      cap              <= '0;
      captured         <= 1'b0;
      tx_cnt           <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n || !shifting) begin
        // frame ended or not yet in a shift state: drop any partial word
        bit_cnt  <= '0;
        shift    <= '0;
        captured <= 1'b0;
        tx_cnt   <= '0;
        MISO     <= 1'b0;
      end else begin
        if (!word_done) begin
          shift   <= {shift[RX_W-3:0], MOSI};
          bit_cnt <= bit_cnt + 1'b1;
          if (word_last) begin
            rx_data  <= {shift, MOSI};
            rx_valid <= 1'b1;
            if (state == READ_ADD) rd_addr_received <= 1'b1;
          end
        end
        if (state == READ_DATA && word_done) begin
          MISO <= 1'b0;
          if (!captured) begin
            if (tx_valid) begin
              cap      <= tx_data;
              captured <= 1'b1;
            end
          end else if (tx_cnt != TW'(TX_W)) begin
            MISO   <= cap[TX_W-1];
            cap    <= {cap[TX_W-2:0], 1'b0};
            tx_cnt <= tx_cnt + 1'b1;
            // flag drops only once the last bit actually goes out
            if (tx_cnt == TW'(TX_W - 1)) rd_addr_received <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: directed frame table plus random frames, checked
// cycle by cycle against a frame-level model of the protocol.
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  spi_slave_if #(.RX_W(10), .TX_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model state: read-address flag and last delivered word
  logic       m_flag = 1'b0;
  logic [9:0] m_rx = 10'h000;

  typedef struct {
    logic       sel;
    logic [9:0] word;
    int         last;      // last edge index (from SS_n-low edge) with SS_n low
    int         d;         // tx_valid delay after the word-complete edge + 1
    logic [7:0] byt;
    int         exp_pulses;
    logic [9:0] exp_rx;
    logic [7:0] exp_mbyte;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one SS_n-low frame followed by one SS_n-high edge. Edge k=0 samples
  // SS_n low, k=1 the selector, k=2..11 the word, k=12+d the RAM data.
  task automatic run_frame(input logic sel, input logic [9:0] word, input int last,
                           input int d, input logic [7:0] byt, input int rst_at,
                           output int pulses, output logic [7:0] mbyte);
    int   mode;   // 0 write, 1 read address, 2 read data
    int   cap_e;
    logic ss, exp_v, exp_m;
    mode   = !sel ? 0 : (m_flag ? 2 : 1);
    cap_e  = 12 + d;
    pulses = 0;
    mbyte  = 8'h00;
    for (int k = 0; k <= last + 1; k++) begin
      ss   = (k > last);
      SS_n = ss;
      if (k == 1)                 MOSI = sel;
      else if (k >= 2 && k <= 11) MOSI = word[11-k];
      else                        MOSI = 1'($urandom);
      if (mode == 2 && k == cap_e) begin
        tx_valid = 1'b1;
        tx_data  = byt;
      end else if (mode == 2 && k >= 12 && k < cap_e) begin
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
      end else begin
        tx_valid = ($urandom_range(0, 2) == 0);
        tx_data  = 8'($urandom);
      end
      @(posedge clk);
      #1;
      exp_v = !ss && (k == 11);
      if (exp_v) begin
        m_rx = word;
        if (mode == 1) m_flag = 1'b1;
      end
      exp_m = 1'b0;
      if (mode == 2 && !ss && last >= cap_e && k > cap_e && k <= cap_e + 8)
        exp_m = byt[cap_e+8-k];
      if (mode == 2 && !ss && k == cap_e + 8) m_flag = 1'b0;
      chk("rx_valid", 32'(rx_valid), 32'(exp_v));
      chk("rx_data", 32'(rx_data), 32'(m_rx));
      chk("MISO", 32'(MISO), 32'(exp_m));
      if (rx_valid) pulses++;
      if (mode == 2 && MISO && k > cap_e && k <= cap_e + 8) mbyte[cap_e+8-k] = 1'b1;
      if (k == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        m_flag = 1'b0;
        m_rx   = 10'h000;
        chk("async_rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("async_rst_rx_data", 32'(rx_data), 32'd0);
        chk("async_rst_MISO", 32'(MISO), 32'd0);
        SS_n = 1'b1;
        tx_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        break;
      end
    end
    tx_valid = 1'b0;
  endtask

  vec_t vt[12];
  int   pulses;
  logic [7:0] mbyte;

  initial begin
    vt[0]  = '{1'b0, 10'h012, 13, 0, 8'h00, 1, 10'h012, 8'h00};
    vt[1]  = '{1'b0, 10'h1A5, 12, 0, 8'h00, 1, 10'h1A5, 8'h00};
    vt[2]  = '{1'b1, 10'h212, 12, 0, 8'h00, 1, 10'h212, 8'h00};
    vt[3]  = '{1'b1, 10'h300, 24, 2, 8'hA5, 1, 10'h300, 8'hA5};
    vt[4]  = '{1'b0, 10'h3FF,  6, 0, 8'h00, 0, 10'h300, 8'h00};  // abort after 5 bits
    vt[5]  = '{1'b0, 10'h0AB, 12, 0, 8'h00, 1, 10'h0AB, 8'h00};
    vt[6]  = '{1'b1, 10'h111, 12, 0, 8'h00, 1, 10'h111, 8'h00};  // flag was cleared
    vt[7]  = '{1'b1, 10'h222, 16, 1, 8'hFF, 1, 10'h222, 8'hE0};  // abort mid-serialise
    vt[8]  = '{1'b1, 10'h333, 22, 0, 8'h3C, 1, 10'h333, 8'h3C};  // retry data phase
    vt[9]  = '{1'b0, 10'h155, 16, 0, 8'h00, 1, 10'h155, 8'h00};  // 15 bits after selector
    vt[10] = '{1'b1, 10'h0F0,  3, 0, 8'h00, 0, 10'h155, 8'h00};
    vt[11] = '{1'b1, 10'h0F0, 12, 0, 8'h00, 1, 10'h0F0, 8'h00};

    // reset held with SS_n low and MOSI toggling
    SS_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      MOSI = i[0];
      @(posedge clk);
      #1;
      chk("rst_rx_valid", 32'(rx_valid), 32'd0);
      chk("rst_rx_data", 32'(rx_data), 32'd0);
      chk("rst_MISO", 32'(MISO), 32'd0);
    end
    SS_n = 1'b1;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      MOSI = 1'($urandom);
      @(posedge clk);
      #1;
      chk("idle_rx_valid", 32'(rx_valid), 32'd0);
      chk("idle_MISO", 32'(MISO), 32'd0);
    end

    for (int i = 0; i < 12; i++) begin
      run_frame(vt[i].sel, vt[i].word, vt[i].last, vt[i].d, vt[i].byt, -1, pulses, mbyte);
      chk($sformatf("vec%0d_pulses", i), 32'(pulses), 32'(vt[i].exp_pulses));
      chk($sformatf("vec%0d_rx_data", i), 32'(rx_data), 32'(vt[i].exp_rx));
      chk($sformatf("vec%0d_miso_byte", i), 32'(mbyte), 32'(vt[i].exp_mbyte));
    end

    // async reset in the middle of serialising read data: flag must drop too
    run_frame(1'b1, 10'h2C4, 12, 0, 8'h00, -1, pulses, mbyte);   // address phase
    run_frame(1'b1, 10'h3C4, 30, 0, 8'hFF, 15, pulses, mbyte);   // reset at edge 15
    run_frame(1'b1, 10'h045, 12, 0, 8'h00, -1, pulses, mbyte);
    chk("post_rst_is_read_addr", 32'(m_flag), 32'd1);

    // random frames, mostly complete, some aborted at arbitrary points
    for (int i = 0; i < 60; i++) begin
      int last;
      last = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 22)) : int'($urandom_range(12, 26));
      run_frame(1'($urandom), 10'($urandom), last, int'($urandom_range(0, 4)),
                8'($urandom), -1, pulses, mbyte);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
